bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter (iterative shift-add-3, one bit per clock) between the CPU's A-register output and the four-digit 7-segment display driver.
- Latches an accumulator value on `start`, converts over WIDTH+1 cycles, then holds registered BCD digits plus a leading-zero blank mask until the next conversion.
- Runs on the fast board clock, so the display updates within microseconds of a CPU register change.

---
 rtl/bcd_converter.sv | 191 +++++++++++++++++++
 tb/tb_bcd_converter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD converter (shift-add-3, one input bit per clock) feeding the display driver.
// Optional two's-complement input handling is enabled by defining BCD_CONVERTER_SIGNED_EN.
module bcd_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_btn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  overflow,
   output logic                  neg
);

   localparam int                  CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(1);
   localparam logic [DIGITS-1:0]   BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_s;
   logic [WIDTH-1:0]       bin_r;
   logic [4*DIGITS-1:0]    scratch_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   ovf_r;

   logic [WIDTH-1:0]       mag_s;
   logic [4*DIGITS-1:0]    adj_s;
   logic [4*DIGITS-1:0]    shift_scratch_s;
   logic [WIDTH-1:0]       shift_bin_s;
   logic                   carry_s;
   logic [DIGITS-1:0]      blank_s;

   // Per-digit correction: each digit is adjusted independently, no carry between digits.
   function automatic logic [3:0] add3(input logic [3:0] d);
      logic [3:0] r;
      if (d >= 4'd5) begin
         r = d + 4'd3;
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Magnitude of the input value that enters the binary shift register.
`ifdef BCD_CONVERTER_SIGNED_EN
   always_comb begin
      mag_s = value;
      if (value[WIDTH-1]) begin
         // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits
         mag_s = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         mag_s = value;
      end
   end
`else
   always_comb begin
      mag_s = value;
   end
`endif

   // One shift-add-3 step: adjust digits, then shift {scratch, binary} left by one.
   always_comb begin
      adj_s = '0;
      for (int i = 0; i < DIGITS; i++) begin
         adj_s[4*i +: 4] = add3(scratch_r[4*i +: 4]);
      end
      shift_scratch_s = {adj_s[4*DIGITS-2:0], bin_r[WIDTH-1]};
      shift_bin_s     = {bin_r[WIDTH-2:0], 1'b0};
      carry_s         = adj_s[4*DIGITS-1];
   end

   // Leading-zero mask: a digit blanks when it and every digit above it are zero.
   always_comb begin
      logic zero_above;
      blank_s    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (scratch_r[4*i +: 4] == 4'd0);
         blank_s[i] = zero_above;
      end
      blank_s[0] = 1'b0;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CNT_LAST) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered outputs; results only move at the DONE edge.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         bin_r     <= '0;
         scratch_r <= '0;
         cnt_r     <= '0;
         ovf_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd       <= '0;
         blank     <= BLANK_RST;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  bin_r     <= mag_s;
                  scratch_r <= '0;
                  ovf_r     <= 1'b0;
                  cnt_r     <= CNT_LOAD;
                  busy      <= 1'b1;
               end
            end
            SHIFT: begin
               scratch_r <= shift_scratch_s;
               bin_r     <= shift_bin_s;
               cnt_r     <= cnt_r - CNT_LAST;
               if (carry_s) begin
                  ovf_r <= 1'b1;
               end
            end
            DONE: begin
               bcd      <= scratch_r;
               blank    <= blank_s;
               overflow <= ovf_r;
               done     <= 1'b1;
               busy     <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef BCD_CONVERTER_SIGNED_EN
   logic neg_pend_r;

   // Sign captured with the value, published alongside the digits.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         neg_pend_r <= 1'b0;
         neg        <= 1'b0;
      end else if (state_r == IDLE && start) begin
         neg_pend_r <= value[WIDTH-1];
      end else if (state_r == DONE) begin
         neg <= neg_pend_r;
      end
   end
`else
   assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter: an 8-bit/4-digit instance and a 16-bit/4-digit instance.
module tb_bcd_converter;

   logic        clk = 1'b0;
   logic        rst_btn = 1'b0;

   logic        start8 = 1'b0;
   logic [7:0]  value8 = 8'd0;
   logic        busy8, done8, ovf8, neg8;
   logic [15:0] bcd8;
   logic [3:0]  blank8;

   logic        start16 = 1'b0;
   logic [15:0] value16 = 16'd0;
   logic        busy16, done16, ovf16, neg16;
   logic [15:0] bcd16;
   logic [3:0]  blank16;

   int checks = 0;
   int errors = 0;
   int lat, bcnt, glitch;

   always #5 clk = ~clk;

   bcd_converter #(.WIDTH(8), .DIGITS(4)) dut8 (
      .clk(clk), .rst_btn(rst_btn), .start(start8), .value(value8),
      .busy(busy8), .done(done8), .bcd(bcd8), .blank(blank8),
      .overflow(ovf8), .neg(neg8)
   );

   bcd_converter #(.WIDTH(16), .DIGITS(4)) dut16 (
      .clk(clk), .rst_btn(rst_btn), .start(start16), .value(value16),
      .busy(busy16), .done(done16), .bcd(bcd16), .blank(blank16),
      .overflow(ovf16), .neg(neg16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; pulses start for one edge, returns at the negedge where done is seen.
   // lat = posedges after the accepting edge, bcnt = busy-high samples, glitch = bcd moved before done.
   task automatic run(input bit wide, input logic [15:0] v,
                      output int l, output int b, output int g);
      logic [15:0] bcd_before;
      bcd_before = wide ? bcd16 : bcd8;
      if (wide) begin value16 = v; start16 = 1'b1; end
      else      begin value8 = v[7:0]; start8 = 1'b1; end
      @(negedge clk);
      start8 = 1'b0;
      start16 = 1'b0;
      l = 0; b = 0; g = 0;
      while (!(wide ? done16 : done8) && l < 40) begin
         if (wide ? busy16 : busy8) b++;
         if ((wide ? bcd16 : bcd8) !== bcd_before) g = 1;
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_done", {31'd0, done8}, 32'd0);
      chk("rst_bcd", {16'd0, bcd8}, 32'h0000);
      chk("rst_blank", {28'd0, blank8}, 32'b1110);
      chk("rst_ovf", {31'd0, ovf8}, 32'd0);
      chk("rst_neg", {31'd0, neg8}, 32'd0);
      chk("rst_blank16", {28'd0, blank16}, 32'b1110);
      @(negedge clk);
      rst_btn = 1'b1;
      @(negedge clk);

      // zero
      run(1'b0, 16'd0, lat, bcnt, glitch);
      chk("zero_lat", lat, 32'd9);
      chk("zero_bcd", {16'd0, bcd8}, 32'h0000);
      chk("zero_blank", {28'd0, blank8}, 32'b1110);
      chk("zero_ovf", {31'd0, ovf8}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done8}, 32'd0);

      // 255: busy window, done width, no output motion during SHIFT
      run(1'b0, 16'd255, lat, bcnt, glitch);
      chk("b255_lat", lat, 32'd9);
      chk("b255_busy_cycles", bcnt, 32'd9);
      chk("b255_no_glitch", glitch, 32'd0);
      chk("b255_busy_at_done", {31'd0, busy8}, 32'd0);
`ifdef BCD_CONVERTER_SIGNED_EN
      chk("b255_bcd", {16'd0, bcd8}, 32'h0001);
      chk("b255_blank", {28'd0, blank8}, 32'b1110);
      chk("b255_neg", {31'd0, neg8}, 32'd1);
`else
      chk("b255_bcd", {16'd0, bcd8}, 32'h0255);
      chk("b255_blank", {28'd0, blank8}, 32'b1000);
      chk("b255_neg", {31'd0, neg8}, 32'd0);
`endif
      @(negedge clk);
      chk("b255_done_low", {31'd0, done8}, 32'd0);
      @(negedge clk);

      // 100 with an ignored start while busy
      value8 = 8'd100; start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      @(negedge clk); @(negedge clk);
      value8 = 8'd7; start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 40) begin @(negedge clk); lat++; end
      chk("busy_start_done_seen", {31'd0, done8}, 32'd1);
      chk("busy_start_ignored", {16'd0, bcd8}, 32'h0100);
      chk("b100_blank", {28'd0, blank8}, 32'b1000);
      // start during the done cycle is accepted
      run(1'b0, 16'd7, lat, bcnt, glitch);
      chk("b2b_lat", lat, 32'd9);
      chk("b2b_bcd", {16'd0, bcd8}, 32'h0007);
      chk("b2b_blank", {28'd0, blank8}, 32'b1110);
      @(negedge clk);

      // reset mid-conversion of 200
      value8 = 8'd200; start8 = 1'b1;
      @(negedge clk); start8 = 1'b0;
      repeat (4) @(negedge clk);
      rst_btn = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      chk("abort_bcd", {16'd0, bcd8}, 32'h0000);
      chk("abort_blank", {28'd0, blank8}, 32'b1110);
      @(negedge clk);
      rst_btn = 1'b1;
      glitch = 0;
      repeat (15) begin @(negedge clk); if (done8) glitch = 1; end
      chk("abort_no_done", glitch, 32'd0);
      run(1'b0, 16'd42, lat, bcnt, glitch);
      chk("after_abort_bcd", {16'd0, bcd8}, 32'h0042);
      chk("after_abort_lat", lat, 32'd9);
      @(negedge clk);

      // 16-bit instance: overflow and full-width result
      run(1'b1, 16'd12345, lat, bcnt, glitch);
      chk("w16_lat", lat, 32'd17);
      chk("w16_bcd_ovf", {16'd0, bcd16}, 32'h2345);
      chk("w16_ovf", {31'd0, ovf16}, 32'd1);
      @(negedge clk);
      run(1'b1, 16'd9999, lat, bcnt, glitch);
      chk("w16_9999_bcd", {16'd0, bcd16}, 32'h9999);
      chk("w16_9999_ovf", {31'd0, ovf16}, 32'd0);
      chk("w16_9999_blank", {28'd0, blank16}, 32'b0000);
      @(negedge clk);
      run(1'b1, 16'd10000, lat, bcnt, glitch);
      chk("w16_10000_bcd", {16'd0, bcd16}, 32'h0000);
      chk("w16_10000_ovf", {31'd0, ovf16}, 32'd1);
      @(negedge clk);

`ifdef BCD_CONVERTER_SIGNED_EN
      run(1'b0, 16'h0080, lat, bcnt, glitch);
      chk("s80_neg", {31'd0, neg8}, 32'd1);
      chk("s80_bcd", {16'd0, bcd8}, 32'h0128);
      @(negedge clk);
      run(1'b0, 16'h007F, lat, bcnt, glitch);
      chk("s7f_neg", {31'd0, neg8}, 32'd0);
      chk("s7f_bcd", {16'd0, bcd8}, 32'h0127);
      @(negedge clk);
`else
      run(1'b0, 16'd128, lat, bcnt, glitch);
      chk("u128_bcd", {16'd0, bcd8}, 32'h0128);
      chk("u128_neg", {31'd0, neg8}, 32'd0);
      @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
